// File: rtl/ap_ctrl_sequencer_if.sv
// Command and ap_ctrl_chain handshake bundle between the sequencer (master)
// and the kernel/command side (slave).
interface ap_ctrl_sequencer_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TO_W  = 20
);
    logic             cmd_valid;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_ready;
    logic             cmd_abort;
    logic [TO_W-1:0]  timeout_limit;
    logic             cont_en;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] completed;
    logic             finish;
    logic             err_timeout;
    logic             err_spurious;

    modport master (
        input  cmd_valid, cmd_count, cmd_abort, timeout_limit, cont_en,
        input  ap_ready, ap_done,
        output cmd_ready, ap_start, ap_continue, issued, completed,
        output finish, err_timeout, err_spurious
    );

    modport slave (
        output cmd_valid, cmd_count, cmd_abort, timeout_limit, cont_en,
        output ap_ready, ap_done,
        input  cmd_ready, ap_start, ap_continue, issued, completed,
        input  finish, err_timeout, err_spurious
    );
endinterface

// File: rtl/ap_ctrl_sequencer.sv
// Batch initiator for the HLS ap_ctrl_chain handshake: issues a commanded
// number of starts with bounded overlap and retires them via ap_continue.
module ap_ctrl_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned TO_W      = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    ap_ctrl_sequencer_if.master   bus
);
    localparam logic [3:0] MAX_O = 4'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_DRAIN  = 3'd2,
        S_FINISH = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic [3:0]       outst_q, outst_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             err_to_q, err_to_d;
    logic             err_sp_q, err_sp_d;
    logic             start_q, start_d;
    logic             cont_q, cont_d;
    logic             ready_q, ready_d;
    logic             finish_q, finish_d;

    logic             active;
    logic             issue_ev, comp_ev, spur_ev;
    logic [CNT_W-1:0] iss_n, cmp_n;
    logic [3:0]       outst_n;
    logic [TO_W-1:0]  to_n;
    logic             timeout_hit;

    assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign issue_ev = start_q && bus.ap_ready && (issued_q < target_q);
    // A done with nothing outstanding is never counted, only flagged.
    assign comp_ev  = cont_q && bus.ap_done && (outst_q != 4'd0) && (completed_q < target_q);
    assign spur_ev  = active && bus.ap_done && (outst_q == 4'd0);

    assign iss_n   = issued_q + CNT_W'(issue_ev);
    assign cmp_n   = completed_q + CNT_W'(comp_ev);
    assign outst_n = outst_q + 4'(issue_ev) - 4'(comp_ev);

    assign to_n        = (issue_ev || comp_ev) ? '0 :
                         (to_q == '1)          ? to_q : to_q + TO_W'(1);
    assign timeout_hit = (bus.timeout_limit != '0) && (to_n == bus.timeout_limit);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        issued_d    = issued_q;
        completed_d = completed_q;
        outst_d     = outst_q;
        to_d        = to_q;
        err_to_d    = err_to_q;
        err_sp_d    = err_sp_q;

        if (active) begin
            issued_d    = iss_n;
            completed_d = cmp_n;
            outst_d     = outst_n;
            to_d        = to_n;
            if (spur_ev) begin
                err_sp_d = 1'b1;
            end
        end

        if (bus.cmd_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ready_q && bus.cmd_valid) begin
                        target_d    = bus.cmd_count;
                        issued_d    = '0;
                        completed_d = '0;
                        outst_d     = '0;
                        to_d        = '0;
                        err_to_d    = 1'b0;
                        err_sp_d    = 1'b0;
                        state_d     = (bus.cmd_count == '0) ? S_FINISH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (timeout_hit) begin
                        state_d  = S_ERR;
                        err_to_d = 1'b1;
                    end else if (iss_n == target_q) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (timeout_hit) begin
                        state_d  = S_ERR;
                        err_to_d = 1'b1;
                    end else if (cmp_n == target_q) begin
                        state_d = S_FINISH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                S_ERR:    state_d = S_ERR;
                default:  state_d = S_IDLE;
            endcase
        end

        // Outputs are registered, so they are derived from the post-event next state.
        ready_d  = (state_d == S_IDLE);
        finish_d = (state_d == S_FINISH);
        start_d  = (state_d == S_RUN) && (issued_d < target_d) && (outst_d < MAX_O);
        cont_d   = bus.cont_en && ((state_d == S_RUN) || (state_d == S_DRAIN));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            target_q    <= '0;
            issued_q    <= '0;
            completed_q <= '0;
            outst_q     <= '0;
            to_q        <= '0;
            err_to_q    <= 1'b0;
            err_sp_q    <= 1'b0;
            start_q     <= 1'b0;
            cont_q      <= 1'b0;
            ready_q     <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            issued_q    <= issued_d;
            completed_q <= completed_d;
            outst_q     <= outst_d;
            to_q        <= to_d;
            err_to_q    <= err_to_d;
            err_sp_q    <= err_sp_d;
            start_q     <= start_d;
            cont_q      <= cont_d;
            ready_q     <= ready_d;
            finish_q    <= finish_d;
        end
    end

    assign bus.cmd_ready    = ready_q;
    assign bus.ap_start     = start_q;
    assign bus.ap_continue  = cont_q;
    assign bus.issued       = issued_q;
    assign bus.completed    = completed_q;
    assign bus.finish       = finish_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_spurious = err_sp_q;
endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Bench for ap_ctrl_sequencer: a behavioural kernel with configurable ready and
// done latency, plus a per-batch scoreboard compared on each finish pulse.
module tb_ap_ctrl_sequencer;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned TO_W      = 20;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ap_ctrl_sequencer_if #(.CNT_W(CNT_W), .TO_W(TO_W)) bus ();

    ap_ctrl_sequencer #(
        .CNT_W    (CNT_W),
        .MAX_OUTST(MAX_OUTST),
        .TO_W     (TO_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Kernel model state and statistics
    int ready_lat = 0;   // -1 never ready, 0 tied high, N after N start cycles
    int done_lat  = 5;
    bit force_done = 1'b0;
    int kq[$];
    int exp_q[$];
    int iss_cyc[$];
    int cmp_cyc[$];
    int cyc = 0;
    int age = 0;
    bit iss_pend = 1'b0;
    bit cmp_pend = 1'b0;
    bit prev_fin = 1'b0;
    int iss_cnt = 0, cmp_cnt = 0, max_out = 0, start_hi = 0, fin_cnt = 0;
    int acc_cyc = 0;

    always @(posedge clock) cyc++;

    // Handshakes at a rising edge are accounted at the following falling edge.
    always @(negedge clock) begin
        if (!reset) begin
            kq.delete();
            exp_q.delete();
            iss_pend    = 1'b0;
            cmp_pend    = 1'b0;
            prev_fin    = 1'b0;
            age         = 0;
            bus.ap_ready = 1'b0;
            bus.ap_done  = 1'b0;
        end else begin
            if (iss_pend) begin
                kq.push_back(cyc + done_lat);
                iss_cnt++;
                iss_cyc.push_back(cyc);
                age = 0;
            end
            if (cmp_pend && kq.size() > 0) begin
                void'(kq.pop_front());
                cmp_cnt++;
                cmp_cyc.push_back(cyc);
            end
            if (iss_cnt - cmp_cnt > max_out) max_out = iss_cnt - cmp_cnt;

            if (bus.ap_start) start_hi++;
            if (prev_fin) check("ready_after_finish", bus.cmd_ready, 1);
            if (bus.finish) begin
                fin_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_finish", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("sb_issued", bus.issued, e);
                    check("sb_completed", bus.completed, e);
                    check("sb_err_timeout", bus.err_timeout, 0);
                    check("sb_err_spurious", bus.err_spurious, 0);
                end
            end
            prev_fin = bus.finish;

            if (ready_lat < 0) begin
                bus.ap_ready = 1'b0;
            end else if (ready_lat == 0) begin
                bus.ap_ready = 1'b1;
            end else begin
                age = bus.ap_start ? age + 1 : 0;
                bus.ap_ready = bus.ap_start && (age >= ready_lat);
            end
            bus.ap_done = force_done || ((kq.size() > 0) ? (kq[0] <= cyc) : 1'b0);
            iss_pend = bus.ap_start && bus.ap_ready;
            cmp_pend = bus.ap_done && bus.ap_continue;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_stats();
        iss_cnt = 0; cmp_cnt = 0; max_out = 0; start_hi = 0; fin_cnt = 0;
        iss_cyc.delete();
        cmp_cyc.delete();
    endtask

    task automatic drive_cmd(input int n, input bit expect_finish);
        int g;
        g = 0;
        while (!bus.cmd_ready && g < 200) begin
            tick();
            g++;
        end
        if (!bus.cmd_ready) check("cmd_ready_wait", bus.cmd_ready, 1);
        if (expect_finish) exp_q.push_back(n);
        bus.cmd_count = CNT_W'(n);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int bound);
        int g;
        g = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && g < bound) begin
            tick();
            g++;
        end
        check("batch_retired", (exp_q.size() == 0) && bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected summary before time limit");
        $fatal(1);
    end

    initial begin
        int g;
        int bad;
        reset = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_count     = '0;
        bus.cmd_abort     = 1'b0;
        bus.timeout_limit = '0;
        bus.cont_en       = 1'b1;

        // Reset state
        tick();
        check("rst_ap_start", bus.ap_start, 0);
        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_finish", bus.finish, 0);
        reset = 1'b1;
        check("ready_before_edge", bus.cmd_ready, 0);
        tick();
        check("ready_after_release", bus.cmd_ready, 1);

        // Single transaction, ready 2 cycles after start
        clear_stats();
        ready_lat = 2; done_lat = 5;
        drive_cmd(1, 1'b1);
        wait_done(100);
        check("t1_issues", iss_cnt, 1);
        check("t1_start_cycles", start_hi, 2);
        check("t1_finish_cnt", fin_cnt, 1);

        // Back-to-back burst limited by MAX_OUTST
        clear_stats();
        ready_lat = 0; done_lat = 10;
        drive_cmd(8, 1'b1);
        wait_done(300);
        check("t2_max_outst", max_out, MAX_OUTST);
        check("t2_issues", iss_cnt, 8);
        check("t2_completions", cmp_cnt, 8);
        check("t2_finish_cnt", fin_cnt, 1);
        check("t2_burst_span", (iss_cyc.size() >= 4) ? iss_cyc[3] - iss_cyc[0] : -1, 3);

        // Back-pressure on ap_continue
        clear_stats();
        bus.cont_en = 1'b0; done_lat = 3;
        drive_cmd(2, 1'b1);
        g = 0;
        while (!bus.ap_done && g < 50) begin tick(); g++; end
        check("t3_done_seen", bus.ap_done, 1);
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.ap_continue || bus.completed != '0 || !bus.ap_done) bad++;
        end
        check("t3_bp_hold", bad, 0);
        check("t3_completed_frozen", bus.completed, 0);
        bus.cont_en = 1'b1;
        wait_done(100);
        check("t3_completions", cmp_cnt, 2);
        check("t3_resume_gap", (cmp_cyc.size() >= 2) ? cmp_cyc[1] - cmp_cyc[0] : -1, 1);

        // Zero-count command
        clear_stats();
        drive_cmd(0, 1'b1);
        check("t4_finish_next", bus.finish, 1);
        tick();
        check("t4_ready", bus.cmd_ready, 1);
        check("t4_no_start", start_hi, 0);

        // Timeout into ERR, then abort
        clear_stats();
        bus.timeout_limit = TO_W'(50); ready_lat = -1;
        drive_cmd(3, 1'b0);
        g = 0;
        while (!bus.err_timeout && g < 200) begin tick(); g++; end
        check("t5_to_latency", cyc - acc_cyc, 50);
        check("t5_start_low", bus.ap_start, 0);
        check("t5_ready_low", bus.cmd_ready, 0);
        check("t5_cont_low", bus.ap_continue, 0);
        tick();
        check("t5_err_held", bus.cmd_ready, 0);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check("t5_abort_ready", bus.cmd_ready, 1);
        check("t5_err_sticky", bus.err_timeout, 1);
        check("t5_no_finish", fin_cnt, 0);

        // Spurious done before any issue
        clear_stats();
        bus.timeout_limit = '0;
        drive_cmd(2, 1'b0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("t6_err_spurious", bus.err_spurious, 1);
        check("t6_completed", bus.completed, 0);
        check("t6_still_run", bus.ap_start, 1);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check("t6_abort_ready", bus.cmd_ready, 1);

        // Reset in the middle of a batch
        clear_stats();
        ready_lat = 0; done_lat = 10;
        drive_cmd(6, 1'b1);
        g = 0;
        while (iss_cnt < 3 && g < 50) begin tick(); g++; end
        reset = 1'b0;
        #1;
        check("t7_rst_start", bus.ap_start, 0);
        check("t7_rst_issued", bus.issued, 0);
        check("t7_rst_cont", bus.ap_continue, 0);
        check("t7_rst_ready", bus.cmd_ready, 0);
        tick();
        tick();
        reset = 1'b1;
        clear_stats();
        drive_cmd(3, 1'b1);
        wait_done(100);
        check("t7_issues", iss_cnt, 3);
        check("t7_completions", cmp_cnt, 3);
        check("t7_finish_cnt", fin_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ap_ctrl_sequencer.md
# ap_ctrl_sequencer

Synthesizable initiator for the HLS block-level `ap_ctrl_chain` handshake. It drives `ap_start`/`ap_continue` into a kernel under test (e.g. `mul_top`) and consumes `ap_ready`/`ap_done`. It issues a commanded number of transactions with bounded overlap, counts issue and completion, and pulses `finish` when all transactions have retired. It is the active counterpart of the passive module-status monitor, and its `finish` feeds that monitor's `finish` input.

## Interface
- `CNT_W`, 16: width of transaction count and counters.
- `MAX_OUTST`, 4: maximum transactions issued but not yet completed (1..15).
- `TO_W`, 20: width of the no-progress timeout counter.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: request to run a batch.
- `cmd_count` in CNT_W: number of transactions in the batch.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_abort` in 1: forces return to IDLE from any state.
- `timeout_limit` in TO_W: no-progress cycle limit; 0 disables the timeout.
- `cont_en` in 1: downstream sink can absorb a result (back-pressure).
- `ap_start` out 1: start request to the kernel.
- `ap_ready` in 1: kernel accepted its inputs.
- `ap_done` in 1: kernel result valid; held by the kernel until `ap_continue`.
- `ap_continue` out 1: acknowledges `ap_done`.
- `issued` out CNT_W: start handshakes completed in this batch.
- `completed` out CNT_W: done handshakes completed in this batch.
- `finish` out 1: one-cycle pulse when the batch has retired.
- `err_timeout` out 1: sticky; the no-progress limit was reached.
- `err_spurious` out 1: sticky; `ap_done` arrived with zero transactions outstanding.

## Operation
- **Handshake events:**
  - Issue event: `ap_start & ap_ready` at a rising edge.
  - Completion event: `ap_done & ap_continue` at a rising edge.
  - Outstanding = `issued - completed`, held in a 4-bit counter.
- **States:** IDLE, RUN, DRAIN, FINISH, ERR.
- **IDLE:**
  - `cmd_ready=1`.
  - On `cmd_valid`: latch `target=cmd_count` and clear `issued`, `completed`, both error flags and the timeout counter.
  - If `cmd_count==0`, go to FINISH; otherwise go to RUN.
- **RUN:**
  - `ap_start=1` iff `issued<target` and outstanding<`MAX_OUTST`.
  - When `issued` reaches `target`, go to DRAIN.
- **DRAIN:**
  - `ap_start=0`.
  - When `completed==target`, go to FINISH.
- **`ap_continue`:** equals `cont_en` in RUN and DRAIN; 0 otherwise.
- **FINISH:** `finish=1` for exactly one cycle, then IDLE.
- **Timeout:**
  - In RUN and DRAIN, the counter increments on every cycle with no issue event and no completion event, and clears on any such event.
  - When the counter equals a nonzero `timeout_limit`: go to ERR and set `err_timeout`.
- **ERR:**
  - `ap_start=0`, `ap_continue=0`, `cmd_ready=0`.
  - Held until `cmd_abort`.
- **Spurious done:** `ap_done` with outstanding==0 in RUN or DRAIN sets `err_spurious`. No completion is counted and the state does not change.
- **`cmd_abort`:** has priority over every other transition. Next state is IDLE and `ap_start` drops. Counters and flags hold until the next command.
- **Counter rules:** counters never exceed `target`. An issue event and a completion event in the same cycle both count, so outstanding is unchanged.

## Timing
- While `reset` is low, all outputs are 0 and the state is IDLE. `cmd_ready` rises on the first rising edge after reset release.
- All outputs are registered; next-state values are computed from post-event counts.
  - `ap_start` deasserts in the cycle after the issue event that makes `issued==target` or outstanding==`MAX_OUTST`.
  - `ap_start` is never high for a cycle beyond what those conditions allow.
- Once asserted, `ap_start` stays high until `ap_ready` is seen. The only exceptions are abort and timeout.
- Command accept to first `ap_start` high: 1 cycle.
- Last completion event to `finish` pulse: 1 cycle. The `finish` pulse to `cmd_ready` high: 1 cycle.
- Sustained throughput: one issue per cycle when `ap_ready` is tied high and `MAX_OUTST` is not limiting.
- Reset assertion mid-batch clears everything immediately (asynchronous). No partial-batch state survives.

## Test plan
- **Single transaction:** `cmd_count=1`, kernel with `ap_ready` 2 cycles after start and `ap_done` 5 cycles after start, `cont_en=1` -> exactly one issue, `completed=1`, one `finish` pulse, `cmd_ready` back high.
- **Back-to-back burst:** `cmd_count=8`, `ap_ready` tied 1, kernel latency 10, `MAX_OUTST=4` -> outstanding never exceeds 4, `issued=completed=8`, `finish` once, no errors.
- **Back-pressure:** `cont_en` low for 20 cycles with `ap_done` high -> `ap_continue` low, `completed` frozen, `ap_done` held. On release, completions resume one per cycle.
- **Zero count:** `cmd_count=0` -> no `ap_start`, `finish` 1 cycle after accept.
- **Timeout then abort:** `timeout_limit=50`, kernel never raises `ap_ready` -> `err_timeout` after 50 idle cycles, `ap_start=0`, state ERR. `cmd_abort` -> `cmd_ready=1` next cycle.
- **Spurious done and mid-run reset:**
  - `ap_done` pulsed before any issue -> `err_spurious=1`, `completed=0`.
  - `reset` low during a 6-transaction batch -> all outputs 0 immediately.
  - A new batch after reset release runs cleanly.
